// File: rtl/multi_packet_assembler.sv
// HDMI data-island packet assembler: serialises back-to-back packets (24-bit
// header + four 56-bit subpackets) into the 9-bit per-pixel TERC4 input
// stream, generating the BCH ECC bytes on the fly.
// Optional build macro MULTI_PACKET_ASSEMBLER_NULL_STATS_EN adds a saturating
// count of inserted null packets on output null_count.
module multi_packet_assembler #(
    parameter int MAX_PACKETS = 18,
    parameter int INDEX_WIDTH = 5
) (
    input  logic                   clk_pixel,
    input  logic                   reset,
    input  logic                   data_island_period,
    input  logic [23:0]            header,
    input  logic [3:0][55:0]       sub,
    input  logic                   packet_valid,
    output logic                   packet_ready,
    output logic [8:0]             packet_data,
    output logic                   data_valid,
    output logic                   packet_enable,
    output logic [INDEX_WIDTH-1:0] packet_index,
    output logic [INDEX_WIDTH-1:0] island_packets,
`ifdef MULTI_PACKET_ASSEMBLER_NULL_STATS_EN
    output logic [15:0]            null_count,
`endif
    output logic                   abort
);

    localparam logic [INDEX_WIDTH-1:0] MAX_IDX = INDEX_WIDTH'(MAX_PACKETS);

    logic [4:0]       counter;
    logic [23:0]      hdr_q;
    logic [3:0][55:0] sub_q;
    logic [7:0]       ecc_h;
    logic [3:0][7:0]  ecc_s;

    logic             first;
    logic             handshake;
    logic [23:0]      cur_hdr;
    logic [3:0][55:0] cur_sub;
    logic [7:0]       ecc_h_nxt;
    logic [3:0][7:0]  ecc_s_nxt;
    logic [8:0]       data_nxt;

    // One BCH step, bits fed in transmission order.
    function automatic logic [7:0] bch_step(input logic [7:0] p, input logic b);
        return (p >> 1) ^ ((p[0] ^ b) ? 8'h83 : 8'h00);
    endfunction

    assign first        = (counter == 5'd0);
    assign packet_ready = data_island_period && first && (packet_index < MAX_IDX);
    assign handshake    = packet_valid && packet_ready;

    // Bit selection and ECC update; at counter 0 the packet being latched is
    // used directly so the first pixel needs no extra cycle.
    always_comb begin
        logic [1:0] pair;
        logic [7:0] base;
        cur_hdr   = first ? (handshake ? header : 24'h0) : hdr_q;
        base      = first ? 8'h00 : ecc_h;
        ecc_h_nxt = ecc_h;
        data_nxt  = '0;
        if (counter < 5'd24) begin
            data_nxt[0] = cur_hdr[counter];
            ecc_h_nxt   = bch_step(base, cur_hdr[counter]);
        end else begin
            data_nxt[0] = ecc_h[counter[2:0]];
        end
        ecc_s_nxt = ecc_s;
        cur_sub   = '0;
        for (int k = 0; k < 4; k++) begin
            cur_sub[k] = first ? (handshake ? sub[k] : 56'h0) : sub_q[k];
            base       = first ? 8'h00 : ecc_s[k];
            if (counter < 5'd28) begin
                pair         = {cur_sub[k][{counter, 1'b1}], cur_sub[k][{counter, 1'b0}]};
                ecc_s_nxt[k] = bch_step(bch_step(base, pair[0]), pair[1]);
            end else begin
                pair = {ecc_s[k][{counter[1:0], 1'b1}], ecc_s[k][{counter[1:0], 1'b0}]};
            end
            data_nxt[2*k+1] = pair[0];
            data_nxt[2*k+2] = pair[1];
        end
    end

    // Sequencing, capture, ECC state and registered outputs.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            counter        <= '0;
            packet_index   <= '0;
            island_packets <= '0;
            hdr_q          <= '0;
            sub_q          <= '0;
            ecc_h          <= '0;
            ecc_s          <= '0;
            packet_data    <= '0;
            data_valid     <= 1'b0;
            packet_enable  <= 1'b0;
            abort          <= 1'b0;
`ifdef MULTI_PACKET_ASSEMBLER_NULL_STATS_EN
            null_count     <= '0;
`endif
        end else begin
            data_valid    <= data_island_period;
            packet_enable <= data_island_period && first;
            abort         <= 1'b0;
            if (data_island_period) begin
                packet_data <= data_nxt;
                counter     <= counter + 5'd1;
                ecc_h       <= ecc_h_nxt;
                ecc_s       <= ecc_s_nxt;
                if (first) begin
                    hdr_q <= cur_hdr;
                    sub_q <= cur_sub;
`ifdef MULTI_PACKET_ASSEMBLER_NULL_STATS_EN
                    if (!handshake && null_count != 16'hFFFF)
                        null_count <= null_count + 16'd1;
`endif
                end
                if (counter == 5'd31 && packet_index < MAX_IDX)
                    packet_index <= packet_index + 1'b1;
            end else begin
                // A partial packet is dropped, never replayed.
                packet_data  <= '0;
                counter      <= '0;
                packet_index <= '0;
                ecc_h        <= '0;
                ecc_s        <= '0;
                if (data_valid) begin
                    island_packets <= packet_index;
                    abort          <= !first;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_packet_assembler.sv
// Self-checking bench for multi_packet_assembler: a default instance and a
// MAX_PACKETS=2 instance share stimulus; both are compared every cycle
// against a frame-level reference model.
module tb_multi_packet_assembler;

    localparam int MAXP = 18;
    localparam int CAP  = 2;

    logic             clk_pixel = 1'b0;
    logic             reset;
    logic             data_island_period;
    logic [23:0]      header;
    logic [3:0][55:0] sub;
    logic             packet_valid;
    logic             packet_ready, packet_ready_c;
    logic [8:0]       packet_data, packet_data_c;
    logic             data_valid, data_valid_c;
    logic             packet_enable, packet_enable_c;
    logic [4:0]       packet_index, packet_index_c;
    logic [4:0]       island_packets, island_packets_c;
    logic             abort, abort_c;
`ifdef MULTI_PACKET_ASSEMBLER_NULL_STATS_EN
    logic [15:0]      null_count, null_count_c;
`endif

    always #5 clk_pixel = ~clk_pixel;

    multi_packet_assembler #(.MAX_PACKETS(MAXP), .INDEX_WIDTH(5)) dut (
        .clk_pixel(clk_pixel), .reset(reset), .data_island_period(data_island_period),
        .header(header), .sub(sub), .packet_valid(packet_valid),
        .packet_ready(packet_ready), .packet_data(packet_data), .data_valid(data_valid),
        .packet_enable(packet_enable), .packet_index(packet_index),
        .island_packets(island_packets),
`ifdef MULTI_PACKET_ASSEMBLER_NULL_STATS_EN
        .null_count(null_count),
`endif
        .abort(abort)
    );

    multi_packet_assembler #(.MAX_PACKETS(CAP), .INDEX_WIDTH(5)) dut_cap (
        .clk_pixel(clk_pixel), .reset(reset), .data_island_period(data_island_period),
        .header(header), .sub(sub), .packet_valid(packet_valid),
        .packet_ready(packet_ready_c), .packet_data(packet_data_c), .data_valid(data_valid_c),
        .packet_enable(packet_enable_c), .packet_index(packet_index_c),
        .island_packets(island_packets_c),
`ifdef MULTI_PACKET_ASSEMBLER_NULL_STATS_EN
        .null_count(null_count_c),
`endif
        .abort(abort_c)
    );

    typedef struct {
        int               pos;     // island cycles consumed so far
        logic [31:0][8:0] frame;   // full 32-pixel image of the current packet
        logic [8:0]       data;
        bit               dv;
        bit               en;
        bit               ab;
        int               isl;
        int               nulls;
    } model_t;

    typedef struct {
        logic [23:0] h;
        logic [55:0] s0;
        logic [7:0]  he;
        logic [7:0]  s0e;
    } vec_t;

    model_t     m1, m2;
    vec_t       tbl[3];
    int         n_chk = 0, n_fail = 0;
    int         hs1 = 0, hs2 = 0, ab_cnt = 0;
    int         obs_n = 0;
    logic [8:0] obs[256];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [7:0] bch(input logic [55:0] bits, input int n);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < n; i++)
            p = (p >> 1) ^ ((p[0] ^ bits[i]) ? 8'h83 : 8'h00);
        return p;
    endfunction

    // Whole 32-pixel frame of one packet, built from the packet layout rules.
    function automatic logic [31:0][8:0] build(input logic [23:0] h, input logic [3:0][55:0] s);
        logic [31:0][8:0] f = '0;
        logic [7:0] he = bch({32'h0, h}, 24);
        logic [3:0][7:0] se;
        for (int k = 0; k < 4; k++) se[k] = bch(s[k], 56);
        for (int c = 0; c < 32; c++) begin
            f[c][0] = (c < 24) ? h[c] : he[c-24];
            for (int k = 0; k < 4; k++) begin
                f[c][2*k+1] = (c < 28) ? s[k][2*c]   : se[k][2*(c-28)];
                f[c][2*k+2] = (c < 28) ? s[k][2*c+1] : se[k][2*(c-28)+1];
            end
        end
        return f;
    endfunction

    function automatic model_t mreset();
        model_t m;
        m.pos = 0; m.frame = '0; m.data = '0; m.dv = 0; m.en = 0; m.ab = 0;
        m.isl = 0; m.nulls = 0;
        return m;
    endfunction

    function automatic bit exp_ready(input model_t m, input int mx, input bit d);
        return d && (m.pos % 32 == 0) && (m.pos / 32 < mx);
    endfunction

    function automatic model_t mstep(input model_t m, input int mx, input bit d, input bit v,
                                     input logic [23:0] h, input logic [3:0][55:0] s);
        m.ab = 0;
        if (d) begin
            if (m.pos % 32 == 0) begin
                if (v && (m.pos / 32 < mx)) m.frame = build(h, s);
                else begin
                    m.frame = build(24'h0, '0);
                    if (m.nulls < 65535) m.nulls++;
                end
            end
            m.data = m.frame[m.pos % 32];
            m.dv = 1; m.en = (m.pos % 32 == 0);
            m.pos++;
        end else begin
            if (m.dv) begin
                m.isl = imin(m.pos / 32, mx);
                m.ab  = (m.pos % 32) != 0;
            end
            m.pos = 0; m.data = '0; m.dv = 0; m.en = 0;
        end
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("data", 32'(packet_data), 32'(m1.data));
        chk("data_valid", 32'(data_valid), 32'(m1.dv));
        chk("packet_enable", 32'(packet_enable), 32'(m1.en));
        chk("abort", 32'(abort), 32'(m1.ab));
        chk("packet_index", 32'(packet_index), 32'(imin(m1.pos / 32, MAXP)));
        chk("island_packets", 32'(island_packets), 32'(m1.isl));
        chk("data_cap", 32'(packet_data_c), 32'(m2.data));
        chk("data_valid_cap", 32'(data_valid_c), 32'(m2.dv));
        chk("packet_enable_cap", 32'(packet_enable_c), 32'(m2.en));
        chk("abort_cap", 32'(abort_c), 32'(m2.ab));
        chk("packet_index_cap", 32'(packet_index_c), 32'(imin(m2.pos / 32, CAP)));
        chk("island_packets_cap", 32'(island_packets_c), 32'(m2.isl));
`ifdef MULTI_PACKET_ASSEMBLER_NULL_STATS_EN
        chk("null_count", 32'(null_count), 32'(m1.nulls));
        chk("null_count_cap", 32'(null_count_c), 32'(m2.nulls));
`endif
    endtask

    // One pixel: drive after the falling edge, check ready, step models on the
    // rising edge, check registered outputs on the next falling edge.
    task automatic cycle(input bit d, input bit v, input logic [23:0] h, input logic [3:0][55:0] s);
        data_island_period = d; packet_valid = v; header = h; sub = s;
        #1;
        chk("packet_ready", 32'(packet_ready), 32'(exp_ready(m1, MAXP, d)));
        chk("packet_ready_cap", 32'(packet_ready_c), 32'(exp_ready(m2, CAP, d)));
        if (packet_ready && v) hs1++;
        if (packet_ready_c && v) hs2++;
        @(posedge clk_pixel);
        m1 = mstep(m1, MAXP, d, v, h, s);
        m2 = mstep(m2, CAP, d, v, h, s);
        @(negedge clk_pixel);
        check_outputs();
        if (data_valid && obs_n < 256) begin
            obs[obs_n] = packet_data;
            obs_n++;
        end
        if (abort) ab_cnt++;
    endtask

    task automatic rpkt(output logic [23:0] h, output logic [3:0][55:0] s);
        h = 24'($urandom);
        for (int k = 0; k < 4; k++) s[k] = {24'($urandom), $urandom};
    endtask

    // Single-packet island from the vector table; ECC bytes read off the wire.
    task automatic run_vec(input int i);
        logic [7:0] he, se;
        obs_n = 0;
        for (int c = 0; c < 32; c++) cycle(1, 1, tbl[i].h, {168'h0, tbl[i].s0});
        cycle(0, 0, 24'h0, '0);
        for (int b = 0; b < 8; b++) he[b] = obs[24+b][0];
        for (int j = 0; j < 4; j++) begin
            se[2*j]   = obs[28+j][1];
            se[2*j+1] = obs[28+j][2];
        end
        chk("vec_length", 32'(obs_n), 32'd32);
        chk("vec_header_ecc", 32'(he), 32'(tbl[i].he));
        chk("vec_sub0_ecc", 32'(se), 32'(tbl[i].s0e));
        chk("vec_island_packets", 32'(island_packets), 32'd1);
    endtask

    initial begin
        logic [23:0]      h;
        logic [3:0][55:0] s;
        int               n0;

        tbl[0] = '{h: 24'h0D0282, s0: 56'h0000000000402F, he: 8'hE4, s0e: 8'h71};
        tbl[1] = '{h: 24'h000000, s0: 56'h0,              he: 8'h00, s0e: 8'h00};
        tbl[2] = '{h: 24'h0D0282, s0: 56'h0,              he: 8'hE4, s0e: 8'h00};

        reset = 1'b1; data_island_period = 1'b0; packet_valid = 1'b0;
        header = '0; sub = '0;
        m1 = mreset(); m2 = mreset();
        @(negedge clk_pixel);
        check_outputs();
        chk("reset_ready", 32'(packet_ready), 32'd0);
        reset = 1'b0;
        cycle(0, 1, 24'h0, '0);

        // Fixed vectors, including the reference AVI packet.
        for (int i = 0; i < 3; i++) run_vec(i);

        // Three back-to-back packets.
        hs1 = 0;
        for (int c = 0; c < 96; c++) begin rpkt(h, s); cycle(1, 1, h, s); end
        cycle(0, 0, 24'h0, '0);
        chk("b2b_handshakes", 32'(hs1), 32'd3);
        chk("b2b_island_packets", 32'(island_packets), 32'd3);

        // Underrun at the second boundary.
        n0 = m1.nulls;
        for (int c = 0; c < 64; c++) begin rpkt(h, s); cycle(1, c != 32, h, s); end
        cycle(0, 0, 24'h0, '0);
        chk("underrun_island_packets", 32'(island_packets), 32'd2);
        chk("underrun_null_delta", 32'(m1.nulls - n0), 32'd1);
`ifdef MULTI_PACKET_ASSEMBLER_NULL_STATS_EN
        chk("underrun_null_count", 32'(null_count), 32'(m1.nulls));
`endif

        // Cap instance: only two handshakes in a three-packet island.
        hs2 = 0;
        for (int c = 0; c < 96; c++) begin rpkt(h, s); cycle(1, 1, h, s); end
        cycle(0, 0, 24'h0, '0);
        chk("cap_handshakes", 32'(hs2), 32'd2);
        chk("cap_island_packets", 32'(island_packets_c), 32'd2);

        // Island drops at counter 17, then a clean packet.
        ab_cnt = 0;
        for (int c = 0; c < 17; c++) begin rpkt(h, s); cycle(1, 1, h, s); end
        cycle(0, 0, 24'h0, '0);
        cycle(0, 0, 24'h0, '0);
        chk("abort_pulses", 32'(ab_cnt), 32'd1);
        chk("abort_island_packets", 32'(island_packets), 32'd0);
        run_vec(0);

        // Asynchronous reset at counter 10.
        for (int c = 0; c < 10; c++) cycle(1, 1, tbl[0].h, {168'h0, tbl[0].s0});
        data_island_period = 1'b0; packet_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        m1 = mreset(); m2 = mreset();
        check_outputs();
        chk("reset_mid_ready", 32'(packet_ready), 32'd0);
        @(negedge clk_pixel);
        reset = 1'b0;
        run_vec(0);

        // Random islands, random lengths and valid gaps.
        for (int isl = 0; isl < 15; isl++) begin
            int len = $urandom_range(100, 1);
            for (int c = 0; c < len; c++) begin
                rpkt(h, s);
                cycle(1, $urandom_range(3, 0) != 0, h, s);
            end
            for (int g = 0; g < int'($urandom_range(3, 1)); g++) begin
                rpkt(h, s);
                cycle(0, $urandom_range(1, 0) != 0, h, s);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
